// File: rtl/ysyx_csr_pkg.sv
// ysyx_csr_pkg: shared definitions for the machine-mode CSR file.
//   - CSR addresses, mstatus/mip bit positions, mcause interrupt bit
//   - write-target indices and the address -> write-target decoder
//   - packed mstatus field struct and its read-view packer
package ysyx_csr_pkg;

  typedef logic [11:0] csr_addr_t;

  localparam csr_addr_t CSR_MSTATUS   = 12'h300;
  localparam csr_addr_t CSR_MIE       = 12'h304;
  localparam csr_addr_t CSR_MTVEC     = 12'h305;
  localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
  localparam csr_addr_t CSR_MEPC      = 12'h341;
  localparam csr_addr_t CSR_MCAUSE    = 12'h342;
  localparam csr_addr_t CSR_MTVAL     = 12'h343;
  localparam csr_addr_t CSR_MIP       = 12'h344;
  localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
  localparam csr_addr_t CSR_MINSTRET  = 12'hB02;
  localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
  localparam csr_addr_t CSR_MINSTRETH = 12'hB82;
  localparam csr_addr_t CSR_MVENDORID = 12'hF11;
  localparam csr_addr_t CSR_MARCHID   = 12'hF12;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIP_MTIP = 7;
  localparam int MIP_MEIP = 11;

  localparam int MCAUSE_IRQ_BIT = 31;

  // One bit per software-writable CSR; read-only CSRs have no index.
  localparam int W_MSTATUS   = 0;
  localparam int W_MIE       = 1;
  localparam int W_MTVEC     = 2;
  localparam int W_MSCRATCH  = 3;
  localparam int W_MEPC      = 4;
  localparam int W_MCAUSE    = 5;
  localparam int W_MTVAL     = 6;
  localparam int W_MCYCLE    = 7;
  localparam int W_MCYCLEH   = 8;
  localparam int W_MINSTRET  = 9;
  localparam int W_MINSTRETH = 10;
  localparam int NR_WCSR     = 11;

  typedef struct packed {
    logic [1:0] mpp;
    logic       mpie;
    logic       mie;
  } mstatus_t;

  // Returns a one-hot write target; all-zero for read-only or unknown
  // addresses, which is how those writes get dropped.
  function automatic logic [NR_WCSR-1:0] wdecode(csr_addr_t addr);
    logic [NR_WCSR-1:0] hit;
    hit = '0;
    case (addr)
      CSR_MSTATUS:   hit[W_MSTATUS]   = 1'b1;
      CSR_MIE:       hit[W_MIE]       = 1'b1;
      CSR_MTVEC:     hit[W_MTVEC]     = 1'b1;
      CSR_MSCRATCH:  hit[W_MSCRATCH]  = 1'b1;
      CSR_MEPC:      hit[W_MEPC]      = 1'b1;
      CSR_MCAUSE:    hit[W_MCAUSE]    = 1'b1;
      CSR_MTVAL:     hit[W_MTVAL]     = 1'b1;
      CSR_MCYCLE:    hit[W_MCYCLE]    = 1'b1;
      CSR_MCYCLEH:   hit[W_MCYCLEH]   = 1'b1;
      CSR_MINSTRET:  hit[W_MINSTRET]  = 1'b1;
      CSR_MINSTRETH: hit[W_MINSTRETH] = 1'b1;
      default:       hit = '0;
    endcase
    return hit;
  endfunction

  function automatic logic [31:0] mstatus_pack(mstatus_t s);
    logic [31:0] r;
    r = '0;
    r[MSTATUS_MIE]                   = s.mie;
    r[MSTATUS_MPIE]                  = s.mpie;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = s.mpp;
    return r;
  endfunction

endpackage

// File: rtl/ysyx_csr_if.sv
// ysyx_csr_if: CSR read/write bus between the EXU (master) and the CSR
// file (slave).
//   raddr      - read address          rdata_o    - combinational read data
//   rillegal_o - high when raddr does not decode to any CSR in the file
//   wen/waddr/wdata - NR_WPORT independent write ports
interface ysyx_csr_if #(
  parameter int XLEN     = 32,
  parameter int NR_WPORT = 2
) ();
  import ysyx_csr_pkg::*;

  csr_addr_t                          raddr;
  logic [XLEN-1:0]                    rdata_o;
  logic                               rillegal_o;
  logic [NR_WPORT-1:0]                wen;
  logic [NR_WPORT-1:0][11:0]          waddr;
  logic [NR_WPORT-1:0][XLEN-1:0]      wdata;

  modport master (
    output raddr, wen, waddr, wdata,
    input  rdata_o, rillegal_o
  );

  modport slave (
    input  raddr, wen, waddr, wdata,
    output rdata_o, rillegal_o
  );
endinterface

// File: rtl/ysyx_csr_counter64.sv
// ysyx_csr_counter64: 64-bit wrapping counter with 32-bit software writes.
//   clk, rst (sync, active-low)
//   inc              - count up by one this cycle
//   we_lo / we_hi    - replace low / high half with wdata_lo / wdata_hi
//   count_o          - current 64-bit value
// Any software write suppresses the increment for the whole counter, so
// the written value is exactly what is read the next cycle.
module ysyx_csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc,
  input  logic        we_lo,
  input  logic        we_hi,
  input  logic [31:0] wdata_lo,
  input  logic [31:0] wdata_hi,
  output logic [63:0] count_o
);

  logic [63:0] count_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (we_lo || we_hi) begin
      if (we_lo) count_q[31:0]  <= wdata_lo;
      if (we_hi) count_q[63:32] <= wdata_hi;
    end else if (inc) begin
      count_q <= count_q + 64'd1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ysyx_csr_file.sv
// ysyx_csr_file: machine-mode CSR file.
//   clk, rst         - clock, synchronous active-low reset
//   bus (slave)      - combinational read port + NR_WPORT write ports
//   commit_valid     - one instruction retired (minstret increment)
//   trap_*           - trap entry request with cause / pc / tval
//   mret_valid       - return from trap (ignored when trap_valid is high)
//   irq_mtip/meip    - level interrupt sources, visible through mip
//   irq_pending_o    - mstatus.MIE & |(mie & mip)
//   redirect_*_o     - registered one-cycle PC redirect after trap / mret
//   mtvec_o, mepc_o  - current register values
module ysyx_csr_file
  import ysyx_csr_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          NR_WPORT  = 2,
  parameter logic [31:0] RESET_VAL = 32'h0,
  parameter logic [31:0] MVENDORID = 32'h79737978,
  parameter logic [31:0] MARCHID   = 32'h015fde77
) (
  input  logic            clk,
  input  logic            rst,
  ysyx_csr_if.slave       bus,
  input  logic            commit_valid,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  input  logic            irq_mtip,
  input  logic            irq_meip,
  output logic            irq_pending_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o
);

  mstatus_t        mstatus_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] mip;
  logic [63:0]     mcycle, minstret;

  // ---------------- write-port arbitration ----------------
  logic [NR_WCSR-1:0] port_hit [NR_WPORT];
  logic [NR_WCSR-1:0] csr_we;
  logic [XLEN-1:0]    csr_wd [NR_WCSR];

  for (genvar g = 0; g < NR_WPORT; g++) begin : g_wdec
    assign port_hit[g] = bus.wen[g] ? wdecode(bus.waddr[g]) : '0;
  end

  // Ports are scanned in ascending order, so a later (higher) port that
  // hits the same CSR overwrites an earlier one.
  // NOTE: every always_comb output gets a default first; otherwise a
  // path that leaves it unassigned infers a latch.
  always_comb begin
    csr_we = '0;
    for (int c = 0; c < NR_WCSR; c++) csr_wd[c] = '0;
    for (int p = 0; p < NR_WPORT; p++) begin
      for (int c = 0; c < NR_WCSR; c++) begin
        if (port_hit[p][c]) begin
          csr_we[c] = 1'b1;
          csr_wd[c] = bus.wdata[p];
        end
      end
    end
  end

  // ---------------- trap / mret ----------------
  logic            mret_take;
  logic [XLEN-1:0] mtvec_base, trap_target;

  assign mret_take  = mret_valid && !trap_valid;
  assign mtvec_base = {mtvec_q[XLEN-1:2], 2'b00};
  // Vectored mode only applies to interrupts; 4*cause[30:0] wraps in 32 bits.
  assign trap_target = (mtvec_q[1:0] == 2'b01 && trap_cause[MCAUSE_IRQ_BIT])
                     ? mtvec_base + {trap_cause[XLEN-3:0], 2'b00}
                     : mtvec_base;

  always_ff @(posedge clk) begin
    if (!rst) begin
      mstatus_q        <= '0;
      mie_q            <= RESET_VAL;
      mtvec_q          <= RESET_VAL;
      mscratch_q       <= RESET_VAL;
      mepc_q           <= RESET_VAL;
      mcause_q         <= RESET_VAL;
      mtval_q          <= RESET_VAL;
      redirect_valid_o <= 1'b0;
      redirect_pc_o    <= '0;
    end else begin
      if (csr_we[W_MIE])      mie_q      <= csr_wd[W_MIE];
      if (csr_we[W_MTVEC])    mtvec_q    <= csr_wd[W_MTVEC];
      if (csr_we[W_MSCRATCH]) mscratch_q <= csr_wd[W_MSCRATCH];

      // Hardware trap entry overrides software writes to the same CSRs.
      if (trap_valid) begin
        mepc_q   <= {trap_pc[XLEN-1:2], 2'b00};
        mcause_q <= trap_cause;
        mtval_q  <= trap_tval;
      end else begin
        if (csr_we[W_MEPC])   mepc_q   <= {csr_wd[W_MEPC][XLEN-1:2], 2'b00};
        if (csr_we[W_MCAUSE]) mcause_q <= csr_wd[W_MCAUSE];
        if (csr_we[W_MTVAL])  mtval_q  <= csr_wd[W_MTVAL];
      end

      if (trap_valid) begin
        mstatus_q.mpie <= mstatus_q.mie;
        mstatus_q.mie  <= 1'b0;
        mstatus_q.mpp  <= 2'b11;
      end else if (mret_take) begin
        mstatus_q.mie  <= mstatus_q.mpie;
        mstatus_q.mpie <= 1'b1;
        mstatus_q.mpp  <= 2'b11;
      end else if (csr_we[W_MSTATUS]) begin
        mstatus_q.mie  <= csr_wd[W_MSTATUS][MSTATUS_MIE];
        mstatus_q.mpie <= csr_wd[W_MSTATUS][MSTATUS_MPIE];
        mstatus_q.mpp  <= csr_wd[W_MSTATUS][MSTATUS_MPP_HI:MSTATUS_MPP_LO];
      end

      redirect_valid_o <= trap_valid || mret_take;
      if (trap_valid)     redirect_pc_o <= trap_target;
      else if (mret_take) redirect_pc_o <= mepc_q;
    end
  end

  // ---------------- counters ----------------
  ysyx_csr_counter64 u_mcycle (
    .clk      (clk),
    .rst      (rst),
    .inc      (1'b1),
    .we_lo    (csr_we[W_MCYCLE]),
    .we_hi    (csr_we[W_MCYCLEH]),
    .wdata_lo (csr_wd[W_MCYCLE]),
    .wdata_hi (csr_wd[W_MCYCLEH]),
    .count_o  (mcycle)
  );

  ysyx_csr_counter64 u_minstret (
    .clk      (clk),
    .rst      (rst),
    .inc      (commit_valid),
    .we_lo    (csr_we[W_MINSTRET]),
    .we_hi    (csr_we[W_MINSTRETH]),
    .wdata_lo (csr_wd[W_MINSTRET]),
    .wdata_hi (csr_wd[W_MINSTRETH]),
    .count_o  (minstret)
  );

  // ---------------- interrupts ----------------
  always_comb begin
    mip           = '0;
    mip[MIP_MTIP] = irq_mtip;
    mip[MIP_MEIP] = irq_meip;
  end

  assign irq_pending_o = mstatus_q.mie && |(mie_q & mip);

  // ---------------- read mux ----------------
  always_comb begin
    bus.rdata_o    = '0;
    bus.rillegal_o = 1'b0;
    case (bus.raddr)
      CSR_MSTATUS:   bus.rdata_o = mstatus_pack(mstatus_q);
      CSR_MIE:       bus.rdata_o = mie_q;
      CSR_MIP:       bus.rdata_o = mip;
      CSR_MTVEC:     bus.rdata_o = mtvec_q;
      CSR_MSCRATCH:  bus.rdata_o = mscratch_q;
      CSR_MEPC:      bus.rdata_o = mepc_q;
      CSR_MCAUSE:    bus.rdata_o = mcause_q;
      CSR_MTVAL:     bus.rdata_o = mtval_q;
      CSR_MCYCLE:    bus.rdata_o = mcycle[31:0];
      CSR_MCYCLEH:   bus.rdata_o = mcycle[63:32];
      CSR_MINSTRET:  bus.rdata_o = minstret[31:0];
      CSR_MINSTRETH: bus.rdata_o = minstret[63:32];
      CSR_MVENDORID: bus.rdata_o = MVENDORID;
      CSR_MARCHID:   bus.rdata_o = MARCHID;
      default:       bus.rillegal_o = 1'b1;
    endcase
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

endmodule

// File: tb/tb_ysyx_csr_file.sv
// tb_ysyx_csr_file: bench for ysyx_csr_file. A vector table covers the
// write-port/read-mux behaviour; hand-written sequences cover trap, mret,
// counters, interrupts and reset. Redirect targets are queued when a
// trap/mret is driven and compared when the DUT pulses redirect_valid_o.
module tb_ysyx_csr_file;
  import ysyx_csr_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid, trap_valid, mret_valid;
  logic [31:0] trap_cause, trap_pc, trap_tval;
  logic        irq_mtip, irq_meip;
  logic        irq_pending_o, redirect_valid_o;
  logic [31:0] redirect_pc_o, mtvec_o, mepc_o;

  ysyx_csr_if #(.XLEN(32), .NR_WPORT(2)) bus ();

  ysyx_csr_file #(.XLEN(32), .NR_WPORT(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .commit_valid     (commit_valid),
    .trap_valid       (trap_valid),
    .trap_cause       (trap_cause),
    .trap_pc          (trap_pc),
    .trap_tval        (trap_tval),
    .mret_valid       (mret_valid),
    .irq_mtip         (irq_mtip),
    .irq_meip         (irq_meip),
    .irq_pending_o    (irq_pending_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .mtvec_o          (mtvec_o),
    .mepc_o           (mepc_o)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] redir_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_csr(input string name, input csr_addr_t addr, input logic [31:0] exp);
    bus.raddr = addr;
    #1;
    check(name, bus.rdata_o, exp);
  endtask

  task automatic write1(input int port, input csr_addr_t addr, input logic [31:0] data);
    bus.wen[port]   = 1'b1;
    bus.waddr[port] = addr;
    bus.wdata[port] = data;
  endtask

  task automatic clear_inputs();
    bus.wen      = '0;
    trap_valid   = 1'b0;
    mret_valid   = 1'b0;
    commit_valid = 1'b0;
  endtask

  // Redirect scoreboard: every pulse must match the oldest queued target.
  initial begin
    forever begin
      @(negedge clk);
      if (redirect_valid_o === 1'b1) begin
        if (redir_q.size() == 0) check("redirect_spurious", {31'b0, redirect_valid_o}, 32'd0);
        else check("redirect_pc", redirect_pc_o, redir_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [1:0]  wen;
    csr_addr_t   waddr0;
    logic [31:0] wdata0;
    csr_addr_t   waddr1;
    logic [31:0] wdata1;
    csr_addr_t   raddr;
    logic [31:0] exp_rdata;
    logic        exp_ill;
  } vec_t;

  vec_t vecs [$];

  task automatic add_vec(input string n, input logic [1:0] wen,
                         input csr_addr_t a0, input logic [31:0] d0,
                         input csr_addr_t a1, input logic [31:0] d1,
                         input csr_addr_t ra, input logic [31:0] exp, input logic ill);
    vec_t v;
    v.name = n; v.wen = wen; v.waddr0 = a0; v.wdata0 = d0;
    v.waddr1 = a1; v.wdata1 = d1; v.raddr = ra; v.exp_rdata = exp; v.exp_ill = ill;
    vecs.push_back(v);
  endtask

  initial begin
    add_vec("prio_mscratch", 2'b11, CSR_MSCRATCH, 32'h1,         CSR_MSCRATCH, 32'h2,         CSR_MSCRATCH,  32'h2,         1'b0);
    add_vec("mtvec_wr",      2'b01, CSR_MTVEC,    32'h8000_0001, 12'h000,      32'h0,         CSR_MTVEC,     32'h8000_0001, 1'b0);
    add_vec("mepc_align",    2'b01, CSR_MEPC,     32'h8000_0107, 12'h000,      32'h0,         CSR_MEPC,      32'h8000_0104, 1'b0);
    add_vec("ro_mvendorid",  2'b01, CSR_MVENDORID,32'h0,         12'h000,      32'h0,         CSR_MVENDORID, 32'h79737978,  1'b0);
    add_vec("ro_mip",        2'b10, 12'h000,      32'h0,         CSR_MIP,      32'hFFFF_FFFF, CSR_MIP,       32'h0,         1'b0);
    add_vec("unimpl",        2'b01, 12'h7FF,      32'h1234,      12'h000,      32'h0,         12'h7FF,       32'h0,         1'b1);
    add_vec("mstatus_mask",  2'b01, CSR_MSTATUS,  32'hFFFF_FFFF, 12'h000,      32'h0,         CSR_MSTATUS,   32'h0000_1888, 1'b0);
    add_vec("mstatus_mie",   2'b10, 12'h000,      32'h0,         CSR_MSTATUS,  32'h8,         CSR_MSTATUS,   32'h8,         1'b0);
    add_vec("two_csrs",      2'b11, CSR_MTVAL,    32'hDEAD,      CSR_MCAUSE,   32'h5,         CSR_MCAUSE,    32'h5,         1'b0);
    add_vec("port0_lands",   2'b11, CSR_MTVAL,    32'hBEEF,      CSR_MSCRATCH, 32'h7,         CSR_MTVAL,     32'hBEEF,      1'b0);
    add_vec("marchid",       2'b00, 12'h000,      32'h0,         12'h000,      32'h0,         CSR_MARCHID,   32'h015f_de77, 1'b0);
    add_vec("mscratch_keep", 2'b00, 12'h000,      32'h0,         12'h000,      32'h0,         CSR_MSCRATCH,  32'h7,         1'b0);
    add_vec("prio_mie",      2'b11, CSR_MIE,      32'hFF,        CSR_MIE,      32'h80,        CSR_MIE,       32'h80,        1'b0);

    // ---------------- reset ----------------
    rst = 1'b0;
    clear_inputs();
    bus.raddr = '0; bus.waddr = '0; bus.wdata = '0;
    trap_cause = '0; trap_pc = '0; trap_tval = '0;
    irq_mtip = 1'b0; irq_meip = 1'b0;
    tick();
    tick();
    check_csr("rst_mstatus", CSR_MSTATUS, 32'h0);
    check_csr("rst_mcycle", CSR_MCYCLE, 32'h0);
    check_csr("rst_mtvec", CSR_MTVEC, 32'h0);
    check_csr("rst_mvendorid", CSR_MVENDORID, 32'h79737978);
    bus.raddr = 12'h7FF;
    #1;
    check("rst_illegal", {31'b0, bus.rillegal_o}, 32'd1);
    check("rst_redir_valid", {31'b0, redirect_valid_o}, 32'd0);
    check("rst_redir_pc", redirect_pc_o, 32'h0);
    check("rst_irq_pending", {31'b0, irq_pending_o}, 32'd0);

    rst = 1'b1;
    tick();
    check_csr("mcycle_first", CSR_MCYCLE, 32'd1);
    check_csr("minstret_idle", CSR_MINSTRET, 32'd0);

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      bus.wen      = vecs[i].wen;
      bus.waddr[0] = vecs[i].waddr0;
      bus.wdata[0] = vecs[i].wdata0;
      bus.waddr[1] = vecs[i].waddr1;
      bus.wdata[1] = vecs[i].wdata1;
      tick();
      bus.wen = '0;
      check_csr(vecs[i].name, vecs[i].raddr, vecs[i].exp_rdata);
      check({vecs[i].name, "_ill"}, {31'b0, bus.rillegal_o}, {31'b0, vecs[i].exp_ill});
    end

    // Read-during-write returns the pre-edge value.
    write1(0, CSR_MSCRATCH, 32'h9);
    check_csr("rdw_old", CSR_MSCRATCH, 32'h7);
    tick();
    bus.wen = '0;
    check_csr("rdw_new", CSR_MSCRATCH, 32'h9);

    // ---------------- vectored trap, racing software writes ----------------
    trap_valid = 1'b1;
    trap_cause = 32'h8000_0007;
    trap_pc    = 32'h8000_0104;
    trap_tval  = 32'h1234_5678;
    write1(0, CSR_MEPC, 32'h0);
    write1(1, CSR_MSTATUS, 32'h0);
    redir_q.push_back(32'h8000_001C);
    tick();
    clear_inputs();
    check_csr("trap_mepc", CSR_MEPC, 32'h8000_0104);
    check("trap_mepc_o", mepc_o, 32'h8000_0104);
    check_csr("trap_mstatus", CSR_MSTATUS, 32'h0000_1880);
    check_csr("trap_mcause", CSR_MCAUSE, 32'h8000_0007);
    check("trap_redir_valid", {31'b0, redirect_valid_o}, 32'd1);

    // ---------------- mret ----------------
    mret_valid = 1'b1;
    redir_q.push_back(32'h8000_0104);
    tick();
    clear_inputs();
    check_csr("mret_mstatus", CSR_MSTATUS, 32'h0000_1888);

    // ---------------- trap + mret: trap wins, exception not vectored ----------------
    trap_valid = 1'b1;
    mret_valid = 1'b1;
    trap_cause = 32'h2;
    trap_pc    = 32'h8000_0202;
    trap_tval  = 32'h0;
    redir_q.push_back(32'h8000_0000);
    tick();
    clear_inputs();
    check_csr("both_mstatus", CSR_MSTATUS, 32'h0000_1880);
    check_csr("both_mepc", CSR_MEPC, 32'h8000_0200);
    check("mtvec_o", mtvec_o, 32'h8000_0001);
    tick();
    check("redir_one_cycle", {31'b0, redirect_valid_o}, 32'd0);

    // ---------------- counters ----------------
    write1(0, CSR_MCYCLE, 32'hFFFF_FFFF);
    write1(1, CSR_MCYCLEH, 32'hFFFF_FFFF);
    tick();
    bus.wen = '0;
    check_csr("mcycle_written", CSR_MCYCLE, 32'hFFFF_FFFF);
    check_csr("mcycleh_written", CSR_MCYCLEH, 32'hFFFF_FFFF);
    tick();
    check_csr("mcycle_wrap", CSR_MCYCLE, 32'h0);
    check_csr("mcycleh_wrap", CSR_MCYCLEH, 32'h0);

    commit_valid = 1'b1;
    repeat (3) tick();
    commit_valid = 1'b0;
    check_csr("minstret_3", CSR_MINSTRET, 32'd3);
    commit_valid = 1'b1;
    write1(0, CSR_MINSTRETH, 32'h7);
    tick();
    clear_inputs();
    check_csr("minstret_suppr", CSR_MINSTRET, 32'd3);
    check_csr("minstreth_wr", CSR_MINSTRETH, 32'h7);

    // ---------------- interrupt qualification (mie = 0x80 from table) ----------------
    write1(0, CSR_MSTATUS, 32'h8);
    tick();
    bus.wen = '0;
    irq_mtip = 1'b1;
    #1;
    check("irq_on", {31'b0, irq_pending_o}, 32'd1);
    check_csr("mip_mtip", CSR_MIP, 32'h80);
    irq_meip = 1'b1;
    check_csr("mip_both", CSR_MIP, 32'h880);
    irq_mtip = 1'b0;
    #1;
    check("irq_meip_masked", {31'b0, irq_pending_o}, 32'd0);
    irq_mtip = 1'b1;
    write1(0, CSR_MSTATUS, 32'h0);
    tick();
    bus.wen = '0;
    check("irq_mie_off", {31'b0, irq_pending_o}, 32'd0);

    // ---------------- reset during trap ----------------
    rst        = 1'b0;
    trap_valid = 1'b1;
    trap_cause = 32'h8000_0003;
    trap_pc    = 32'h8000_0300;
    tick();
    clear_inputs();
    check("rst_trap_redir", {31'b0, redirect_valid_o}, 32'd0);
    check_csr("rst_trap_mepc", CSR_MEPC, 32'h0);
    check_csr("rst_trap_mstatus", CSR_MSTATUS, 32'h0);
    check_csr("rst_trap_mcycle", CSR_MCYCLE, 32'h0);
    check_csr("rst_trap_minstreth", CSR_MINSTRETH, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    check("rst_irq_masked", {31'b0, irq_pending_o}, 32'd0);
    check("rst_no_redirect", {31'b0, redirect_valid_o}, 32'd0);

    tick();
    check("redirect_drain", redir_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
